// File: rtl/axi_bfm_pkg.sv
// axi_bfm_pkg: shared FSM state encoding, AXI burst/response codes and size helper.
package axi_bfm_pkg;
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;
    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction
endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: per-burst beat counter with last-beat compare against the registered length.
module burst_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] cnt,
    output logic             last
);
    assign last = cnt == len;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI INCR burst master bridging a command/stream port to AXI.
module axi_burst_master
    import axi_bfm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [ADDR_W-1:0]   axi_awaddr,
    output logic [LEN_W-1:0]    axi_awlen,
    output logic [2:0]          axi_awsize,
    output logic [1:0]          axi_awburst,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    output logic [DATA_W-1:0]   axi_wdata,
    output logic [DATA_W/8-1:0] axi_wstrb,
    output logic                axi_wlast,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    input  logic [1:0]          axi_bresp,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    output logic [ADDR_W-1:0]   axi_araddr,
    output logic [LEN_W-1:0]    axi_arlen,
    output logic [2:0]          axi_arsize,
    output logic [1:0]          axi_arburst,
    input  logic                axi_rvalid,
    output logic                axi_rready,
    input  logic [DATA_W-1:0]   axi_rdata,
    input  logic                axi_rlast,
    input  logic [1:0]          axi_rresp
);
    localparam logic [2:0] SIZE = axi_size(DATA_W);
    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [1:0]        err;
    logic [1:0]        resp_max;
    logic              mis;
    logic              accept;
    logic              w_hs;
    logic              r_hs;
    logic              last;
    // done shares its cycle with IDLE, so hold off acceptance until it drops
    assign cmd_ready   = state == IDLE && !done;
    assign accept      = cmd_valid && cmd_ready;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = len_q;
    assign axi_awsize  = SIZE;
    assign axi_awburst = INCR;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = SIZE;
    assign axi_arburst = INCR;
    assign axi_wvalid  = state == W && wr_valid;
    assign wr_ready    = state == W && axi_wready;
    assign axi_wdata   = wr_data;
    assign axi_wstrb   = wr_strb;
    assign axi_wlast   = state == W && last;
    assign axi_bready  = state == B;
    assign axi_rready  = state == R;
    assign rd_valid    = state == R && axi_rvalid;
    assign rd_data     = axi_rdata;
    assign rd_last     = state == R && axi_rlast;
    assign w_hs        = axi_wvalid && axi_wready;
    assign r_hs        = state == R && axi_rvalid;
    assign resp_max    = axi_rresp > err ? axi_rresp : err;
    burst_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .inc  (w_hs || r_hs),
        .len  (len_q),
        .cnt  (cnt),
        .last (last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            err         <= OKAY;
            mis         <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_arvalid <= 1'b0;
            done        <= 1'b0;
            done_resp   <= OKAY;
        end else begin
            done      <= 1'b0;
            done_resp <= OKAY;
            case (state)
                IDLE: if (accept) begin
                    addr_q      <= cmd_addr;
                    len_q       <= cmd_len;
                    err         <= OKAY;
                    mis         <= 1'b0;
                    axi_awvalid <= cmd_write;
                    axi_arvalid <= !cmd_write;
                    state       <= cmd_write ? AW : AR;
                end
                AW: if (axi_awready) begin
                    axi_awvalid <= 1'b0;
                    state       <= W;
                end
                W: if (w_hs && last) state <= B;
                B: if (axi_bvalid) begin
                    done      <= 1'b1;
                    done_resp <= axi_bresp;
                    state     <= IDLE;
                end
                AR: if (axi_arready) begin
                    axi_arvalid <= 1'b0;
                    state       <= R;
                end
                R: if (r_hs) begin
                    err <= resp_max;
                    if (axi_rlast) begin
                        done      <= 1'b1;
                        done_resp <= (!last || mis) ? SLVERR : resp_max;
                        state     <= IDLE;
                    end else if (last) mis <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    logic unused_cnt;
    assign unused_cnt = ^cnt;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: table-driven burst checks plus hand-written reset-during-burst sequence.
module tb_axi_burst_master;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [63:0] wr_data = 0;
    logic [7:0]  wr_strb = 0;
    logic        rd_valid, rd_last, done;
    logic [63:0] rd_data;
    logic [1:0]  done_resp;
    logic        axi_awvalid, axi_awready = 0;
    logic [31:0] axi_awaddr, axi_araddr;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst;
    logic        axi_wvalid, axi_wready = 0, axi_wlast;
    logic [63:0] axi_wdata;
    logic [7:0]  axi_wstrb;
    logic        axi_bvalid = 0, axi_bready;
    logic [1:0]  axi_bresp = 0;
    logic        axi_arvalid, axi_arready = 0;
    logic        axi_rvalid = 0, axi_rready, axi_rlast = 0;
    logic [63:0] axi_rdata = 0;
    logic [1:0]  axi_rresp = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rlast(axi_rlast), .axi_rresp(axi_rresp)
    );

    typedef struct {
        bit         wr;
        logic [31:0] addr;
        logic [7:0]  len;
        int          aw_delay;
        int          nbeats;
        int          err_beat;
        logic [1:0]  err_resp;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic run_write(input vec_t v);
        issue(1, v.addr, v.len);
        for (int d = 0; d <= v.aw_delay; d++) begin
            axi_awready = (d == v.aw_delay);
            #1;
            chk("awvalid", axi_awvalid, 1);
            chk("awaddr", axi_awaddr, v.addr);
            chk("awlen", axi_awlen, v.len);
            if (d == 0) begin
                chk("awsize", axi_awsize, 3);
                chk("awburst", axi_awburst, 2'b01);
                chk("arvalid_in_aw", axi_arvalid, 0);
            end
            @(negedge clk);
        end
        axi_awready = 0;
        for (int i = 0; i <= int'(v.len); i++) begin
            wr_valid = 1; axi_wready = 1; wr_data = 64'(i + 1); wr_strb = 8'hff;
            #1;
            chk("awvalid_dropped", axi_awvalid, 0);
            chk("wvalid", axi_wvalid, 1);
            chk("wr_ready", wr_ready, 1);
            chk("wdata", axi_wdata, 64'(i + 1));
            chk("wlast", axi_wlast, i == int'(v.len));
            @(negedge clk);
        end
        wr_valid = 0; axi_wready = 0;
        axi_bvalid = 1; axi_bresp = v.exp_resp;
        #1 chk("bready", axi_bready, 1);
        chk("wr_ready_in_b", wr_ready, 0);
        @(negedge clk);
        axi_bvalid = 0; axi_bresp = 0;
        #1;
        chk("done_w", done, 1);
        chk("done_resp_w", done_resp, v.exp_resp);
        chk("cmd_ready_in_done", cmd_ready, 0);
        chk("bready_after", axi_bready, 0);
        @(negedge clk);
        #1;
        chk("done_pulse_w", done, 0);
        chk("cmd_ready_after_w", cmd_ready, 1);
    endtask

    task automatic run_read(input vec_t v);
        issue(0, v.addr, v.len);
        axi_arready = 1;
        #1;
        chk("arvalid", axi_arvalid, 1);
        chk("araddr", axi_araddr, v.addr);
        chk("arlen", axi_arlen, v.len);
        chk("arsize", axi_arsize, 3);
        chk("arburst", axi_arburst, 2'b01);
        chk("rready_in_ar", axi_rready, 0);
        @(negedge clk);
        axi_arready = 0;
        for (int i = 0; i < v.nbeats; i++) begin
            axi_rvalid = 1;
            axi_rdata = 64'hDEADBEEF + 64'(i);
            axi_rresp = (i == v.err_beat) ? v.err_resp : 2'b00;
            axi_rlast = (i == v.nbeats - 1);
            #1;
            chk("arvalid_dropped", axi_arvalid, 0);
            chk("rready", axi_rready, 1);
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, 64'hDEADBEEF + 64'(i));
            chk("rd_last", rd_last, i == v.nbeats - 1);
            chk("done_early", done, 0);
            @(negedge clk);
        end
        axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
        #1;
        chk("done_r", done, 1);
        chk("done_resp_r", done_resp, v.exp_resp);
        chk("rready_after", axi_rready, 0);
        chk("rd_valid_after", rd_valid, 0);
        @(negedge clk);
        #1;
        chk("done_pulse_r", done, 0);
        chk("cmd_ready_after_r", cmd_ready, 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h1000, 8'd3, 0, 0, -1, 2'b00, 2'b00};
        tbl[1] = '{1'b0, 32'h2000, 8'd0, 0, 1, -1, 2'b00, 2'b00};
        tbl[2] = '{1'b0, 32'h3000, 8'd3, 0, 4, 1, 2'b10, 2'b10};
        tbl[3] = '{1'b0, 32'h4000, 8'd3, 0, 2, -1, 2'b00, 2'b10};
        tbl[4] = '{1'b0, 32'h5000, 8'd3, 0, 6, -1, 2'b00, 2'b10};
        tbl[5] = '{1'b1, 32'h6000, 8'd0, 5, 0, -1, 2'b00, 2'b11};
        tbl[6] = '{1'b0, 32'h7000, 8'd1, 0, 2, 0, 2'b01, 2'b01};
        tbl[7] = '{1'b0, 32'h8000, 8'd2, 0, 3, 2, 2'b11, 2'b11};
        #2;
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_done_resp", done_resp, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rready", axi_rready, 0);
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 8; k++)
            if (tbl[k].wr) run_write(tbl[k]);
            else run_read(tbl[k]);
        issue(1, 32'h9000, 8'd3);
        axi_awready = 1;
        @(negedge clk);
        axi_awready = 0;
        #1 chk("wvalid_follows_wr_valid", axi_wvalid, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_valid = 1; axi_wready = 1; wr_data = 64'(i + 1);
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst_mid_wvalid", axi_wvalid, 0);
        chk("rst_mid_wr_ready", wr_ready, 0);
        chk("rst_mid_awvalid", axi_awvalid, 0);
        chk("rst_mid_bready", axi_bready, 0);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        rst_n = 1; wr_valid = 0; axi_wready = 0;
        #1 chk("cmd_ready_after_rst", cmd_ready, 1);
        run_read(tbl[1]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
